// File: rtl/pong_game_ctrl.sv
// Ping-pong game controller: ball movement, hit/miss/early-press detection,
// scoring and winner declaration over a row of LEDs.
module pong_game_ctrl #(
    parameter int unsigned N_LEDS    = 8,
    parameter int unsigned TICK_DIV  = 25000000,
    parameter int unsigned WIN_SCORE = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              btn_l,
    input  logic              btn_r,
    output logic [N_LEDS-1:0] led,
    output logic [3:0]        score_l,
    output logic [3:0]        score_r,
    output logic [5:0]        state,
    output logic [1:0]        winner
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned POS_W = $clog2(N_LEDS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LEFT  = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_RIGHT = '0;
    localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        SERVE     = 6'b000010,
        MOVE_R    = 6'b000100,
        MOVE_L    = 6'b001000,
        POINT     = 6'b010000,
        GAME_OVER = 6'b100000
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] pos;
    logic             serve_right;
    logic             tick;

    // One LED lit at the ball position
    function automatic logic [N_LEDS-1:0] ball(input logic [POS_W-1:0] p);
        return N_LEDS'(1) << p;
    endfunction

    assign tick  = (cnt == CNT_MAX);
    assign state = st;

    // Game FSM with registered display, score and winner outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            st          <= IDLE;
            led         <= '0;
            score_l     <= '0;
            score_r     <= '0;
            winner      <= '0;
            cnt         <= '0;
            pos         <= '0;
            serve_right <= 1'b0;
        end else begin
            // free-running step counter; every transition below restarts it
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            case (st)
                IDLE, GAME_OVER: begin
                    if (start) begin
                        st          <= SERVE;
                        cnt         <= '0;
                        score_l     <= '0;
                        score_r     <= '0;
                        winner      <= '0;
                        serve_right <= 1'b0;
                        pos         <= POS_LEFT;
                        led         <= ball(POS_LEFT);
                    end
                end
                SERVE: begin
                    if (!serve_right && btn_l) begin
                        st  <= MOVE_R;
                        cnt <= '0;
                    end else if (serve_right && btn_r) begin
                        st  <= MOVE_L;
                        cnt <= '0;
                    end
                end
                MOVE_R: begin
                    if (btn_r && pos == POS_RIGHT) begin
                        st  <= MOVE_L;
                        cnt <= '0;
                    end else if (btn_r || (tick && pos == POS_RIGHT)) begin
                        // early press or miss: left scores, right serves next
                        st          <= POINT;
                        cnt         <= '0;
                        score_l     <= score_l + 4'd1;
                        serve_right <= 1'b1;
                        led         <= '1;
                    end else if (tick) begin
                        pos <= pos - POS_W'(1);
                        led <= ball(pos - POS_W'(1));
                    end
                end
                MOVE_L: begin
                    if (btn_l && pos == POS_LEFT) begin
                        st  <= MOVE_R;
                        cnt <= '0;
                    end else if (btn_l || (tick && pos == POS_LEFT)) begin
                        // early press or miss: right scores, left serves next
                        st          <= POINT;
                        cnt         <= '0;
                        score_r     <= score_r + 4'd1;
                        serve_right <= 1'b0;
                        led         <= '1;
                    end else if (tick) begin
                        pos <= pos + POS_W'(1);
                        led <= ball(pos + POS_W'(1));
                    end
                end
                POINT: begin
                    if (tick) begin
                        cnt <= '0;
                        if (score_l == WIN) begin
                            st     <= GAME_OVER;
                            winner <= 2'b10;
                        end else if (score_r == WIN) begin
                            st     <= GAME_OVER;
                            winner <= 2'b01;
                        end else begin
                            st  <= SERVE;
                            pos <= serve_right ? POS_RIGHT : POS_LEFT;
                            led <= ball(serve_right ? POS_RIGHT : POS_LEFT);
                        end
                    end
                end
                default: begin
                    st  <= IDLE;
                    cnt <= '0;
                    led <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a cycle-level game model.
module tb_pong_game_ctrl;

    localparam int N  = 8;
    localparam int TD = 4;
    localparam int WS = 2;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_MR    = 2;
    localparam int P_ML    = 3;
    localparam int P_POINT = 4;
    localparam int P_OVER  = 5;

    logic         CLK, RST, start, btn_l, btn_r;
    logic [N-1:0] led;
    logic [3:0]   score_l, score_r;
    logic [5:0]   state;
    logic [1:0]   winner;

    int checks;
    int failures;

    // model of the game
    int         m_ph, m_pos, m_cnt, m_sl, m_sr, m_srv;
    logic [1:0] m_win;

    pong_game_ctrl #(.N_LEDS(N), .TICK_DIV(TD), .WIN_SCORE(WS)) dut (
        .CLK(CLK), .RST(RST), .start(start), .btn_l(btn_l), .btn_r(btn_r),
        .led(led), .score_l(score_l), .score_r(score_r), .state(state),
        .winner(winner)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_step(input logic r, s, bl, br);
        int nph, npos, nsl, nsr, nsrv;
        logic [1:0] nwin;
        bit tk;
        tk = (m_cnt == TD - 1);
        if (r) begin
            m_ph = P_IDLE; m_pos = 0; m_cnt = 0; m_sl = 0; m_sr = 0;
            m_win = 2'b00; m_srv = 0;
            return;
        end
        nph = m_ph; npos = m_pos; nsl = m_sl; nsr = m_sr; nsrv = m_srv; nwin = m_win;
        case (m_ph)
            P_IDLE, P_OVER: if (s) begin
                nph = P_SERVE; nsl = 0; nsr = 0; nwin = 2'b00; nsrv = 0; npos = N - 1;
            end
            P_SERVE: begin
                if (m_srv == 0 && bl) nph = P_MR;
                else if (m_srv == 1 && br) nph = P_ML;
            end
            P_MR: begin
                if (br && m_pos == 0) nph = P_ML;
                else if (br || (tk && m_pos == 0)) begin
                    nph = P_POINT; nsl = m_sl + 1; nsrv = 1;
                end else if (tk) npos = m_pos - 1;
            end
            P_ML: begin
                if (bl && m_pos == N - 1) nph = P_MR;
                else if (bl || (tk && m_pos == N - 1)) begin
                    nph = P_POINT; nsr = m_sr + 1; nsrv = 0;
                end else if (tk) npos = m_pos + 1;
            end
            P_POINT: if (tk) begin
                if (m_sl == WS) begin nph = P_OVER; nwin = 2'b10; end
                else if (m_sr == WS) begin nph = P_OVER; nwin = 2'b01; end
                else begin nph = P_SERVE; npos = (m_srv == 1) ? 0 : N - 1; end
            end
            default: nph = P_IDLE;
        endcase
        m_cnt = (nph != m_ph || tk) ? 0 : m_cnt + 1;
        m_ph = nph; m_pos = npos; m_sl = nsl; m_sr = nsr; m_srv = nsrv; m_win = nwin;
    endtask

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] one;
        one = N'(1);
        case (m_ph)
            P_IDLE:                return '0;
            P_SERVE, P_MR, P_ML:   return one << m_pos;
            default:               return '1;
        endcase
    endfunction

    task automatic cmp(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // per-cycle comparison of every output against the model
    task automatic compare_all();
        logic [5:0] es;
        es = 6'(1) << m_ph;
        cmp("onehot", int'($onehot(state)), 1);
        cmp("state", int'(state), int'(es));
        cmp("led", int'(led), int'(exp_led()));
        cmp("score_l", int'(score_l), m_sl);
        cmp("score_r", int'(score_r), m_sr);
        cmp("winner", int'(winner), int'(m_win));
    endtask

    task automatic step(input logic r, s, bl, br);
        @(negedge CLK);
        RST = r; start = s; btn_l = bl; btn_r = br;
        @(posedge CLK);
        model_step(r, s, bl, br);
        #1;
        RST = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0;
        RST = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        m_ph = P_IDLE; m_pos = 0; m_cnt = 0; m_sl = 0; m_sr = 0; m_srv = 0; m_win = 2'b00;

        // reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cmp("lit_rst_state", int'(state), 'h01);
        cmp("lit_rst_led", int'(led), 0);

        // start and serve from the left; opponent button ignored
        step(1'b0, 1'b1, 1'b0, 1'b0);
        cmp("lit_serve_led", int'(led), 'h80);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        cmp("lit_serve_hold", int'(state), 'h02);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        cmp("lit_move_r", int'(state), 'h04);

        // travel right with stray btn_l pulses
        for (int i = 0; i < 28; i++) step(1'b0, 1'b0, (i % 5) == 2, 1'b0);
        cmp("lit_right_end", int'(led), 'h01);

        // hit at the right end on the tick cycle
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("lit_hit_state", int'(state), 'h08);
        cmp("lit_hit_score", int'({score_l, score_r}), 0);

        // back to the left, hit, then early press by right
        idle(28);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        cmp("lit_led_08", int'(led), 'h08);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("lit_early_score_l", int'(score_l), 1);
        cmp("lit_point_led", int'(led), 'hFF);
        idle(3);
        cmp("lit_point_hold", int'(state), 'h10);
        idle(1);
        cmp("lit_serve_right", int'(led), 'h01);

        // right serves, left misses
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(32);
        cmp("lit_miss_score_r", int'(score_r), 1);
        idle(4);
        cmp("lit_serve_left", int'(led), 'h80);

        // left serves, right misses -> left wins
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(32);
        cmp("lit_score_l_2", int'(score_l), 2);
        idle(4);
        cmp("lit_game_over", int'(state), 'h20);
        cmp("lit_winner", int'(winner), 2);

        // buttons ignored in GAME_OVER, start restarts
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        cmp("lit_restart", int'({score_l, score_r, 2'b00, winner}), 0);

        // reset mid MOVE_R
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cmp("lit_mid_rst", int'(state), 'h01);

        // early press on the left during MOVE_L
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(31);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        cmp("lit_early_score_r", int'(score_r), 1);
        idle(4);
        cmp("lit_serve_left2", int'(led), 'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game controller for the ping-pong game. It moves the ball across a row of LEDs, detects hits, misses and early presses, keeps score, and declares a winner. It owns a 6-state one-hot FSM whose encoding matches the game's 6-bit state register convention: reset state = 6'b000001, one bit per state. It sits directly upstream of the LED and score display logic, and computes its own next state each cycle.

Parameters:
N_LEDS, 8, number of LEDs in the ball row (>=2); led[N_LEDS-1] is the left end, led[0] is the right end
TICK_DIV, 25000000, clock cycles per ball step and POINT display duration (>=2)
WIN_SCORE, 7, points needed to win (1..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; starts a game
btn_l  input  1  left player button; single-cycle pulse, already synchronized and debounced
btn_r  input  1  right player button; single-cycle pulse, already synchronized and debounced
led  output  N_LEDS  ball display, registered
score_l  output  4  left player score, registered
score_r  output  4  right player score, registered
state  output  6  current one-hot state
winner  output  2  2'b00 none, 2'b10 left, 2'b01 right

Behaviour:
- Interface decision: one clock, CLK; reset is synchronous and active-high, RST.
- States, one-hot:
  - IDLE = 000001
  - SERVE = 000010
  - MOVE_R = 000100
  - MOVE_L = 001000
  - POINT = 010000
  - GAME_OVER = 100000
- state is always exactly one-hot.
- RST (sampled at the edge, has priority over all inputs, valid mid-game):
  - state=IDLE, led=0, score_l=score_r=0, winner=0
  - tick counter=0, pos=0, server=left
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - Cleared on every state transition.
  - "tick" = counter==TICK_DIV-1.
- IDLE:
  - led=0.
  - start -> SERVE; scores cleared, winner=0, server=left.
- SERVE:
  - Ball sits at the server's end: pos=N_LEDS-1 for left, pos=0 for right.
  - Server's own button -> MOVE_R if server is left, MOVE_L if server is right.
  - Opponent's button and ticks are ignored.
- MOVE_R:
  - On tick, pos decrements.
  - btn_r with pos==0 -> hit, MOVE_L (pos stays 0 and starts incrementing on the next tick).
  - btn_r with pos!=0 -> early press, left scores.
  - tick with pos==0 and no btn_r in the same cycle -> miss, left scores.
  - btn_r and tick in the same cycle at pos==0 -> counts as a hit.
  - btn_l is ignored.
- MOVE_L: mirror of MOVE_R; btn_l is valid only at pos==N_LEDS-1.
- Scoring: on the transition into POINT, the scorer's score increments by 1 (no saturation needed, since the game stops at WIN_SCORE).
- POINT:
  - led = all ones for TICK_DIV cycles.
  - On tick: if either score == WIN_SCORE -> GAME_OVER, winner set; otherwise -> SERVE, with server = the player who lost the point.
- GAME_OVER:
  - led = all ones, scores and winner held.
  - start -> SERVE with scores cleared, winner=0, server=left.
- Display: led = one-hot at pos in SERVE/MOVE_R/MOVE_L; 0 in IDLE.
- Latency: every output reflects a state or input change one cycle after the edge that samples it.
- Simultaneous btn_l and btn_r: each is evaluated only in states where it is relevant; the irrelevant one is ignored.

Test Plan:
(bench parameters: N_LEDS=8, TICK_DIV=4, WIN_SCORE=2)
- Assert RST mid-MOVE_R -> next edge: state=000001, led=0, scores=0, winner=00.
- start, then btn_l -> SERVE shows led=8'b1000_0000; after btn_l the state is MOVE_R and led shifts right every 4 cycles, reaching 8'b0000_0001 after 28 cycles.
- At led=8'b0000_0001, pulse btn_r in the same cycle as the tick -> MOVE_L, score_r=0, score_l=0.
- MOVE_R with led=8'b0000_1000, pulse btn_r -> POINT, score_l=1, led=8'hFF for 4 cycles, then SERVE with server right and led=8'b0000_0001.
- No press at the right end -> miss: score_l increments. Second miss -> score_l=2 -> GAME_OVER, winner=2'b10; a following start -> SERVE with scores 0.
- Check every cycle that state is one-hot; btn_l pulses during MOVE_R cause no state change.
